// File: rtl/demux4_buf_pkg.sv
// Shared datapath constants and types for the 1-to-4 buffered demux slice.
package demux4_buf_pkg;

  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned NUM_CH     = 4;
  localparam int unsigned SEL_W      = $clog2(NUM_CH);
  localparam int unsigned CNT_W      = 8;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

endpackage

// File: rtl/demux4_buf_if.sv
// Handshake bus for demux4_buf: one upstream stream, four buffered channels.
interface demux4_buf_if
  import demux4_buf_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_WIDTH
);

  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  in_data;
  logic [SEL_W-1:0]  in_sel;
  logic [NUM_CH-1:0] out_valid;
  logic [NUM_CH-1:0] out_ready;
  logic [WIDTH-1:0]  out_data0;
  logic [WIDTH-1:0]  out_data1;
  logic [WIDTH-1:0]  out_data2;
  logic [WIDTH-1:0]  out_data3;
  logic [CNT_W-1:0]  xfer_count;

  modport master (
    output in_valid, in_data, in_sel, out_ready,
    input  in_ready, out_valid, out_data0, out_data1, out_data2, out_data3,
           xfer_count
  );

  modport slave (
    input  in_valid, in_data, in_sel, out_ready,
    output in_ready, out_valid, out_data0, out_data1, out_data2, out_data3,
           xfer_count
  );

endinterface

// File: rtl/demux4_buf_slot.sv
// One-entry valid/ready buffer slot; data is held after a pop until overwritten or reset.
module demux_slot
  import demux4_buf_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_ready,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  slot_state_e state;

  // A write into a FULL slot only happens alongside a pop (guaranteed by in_ready),
  // so FULL+write simply replaces the word and stays FULL.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= SLOT_EMPTY;
      data  <= '0;
    end else begin
      case (state)
        SLOT_EMPTY: begin
          if (wr_en) begin
            state <= SLOT_FULL;
            data  <= wr_data;
          end
        end
        SLOT_FULL: begin
          if (wr_en) begin
            data <= wr_data;
          end else if (rd_ready) begin
            state <= SLOT_EMPTY;
          end
        end
        default: state <= SLOT_EMPTY;
      endcase
    end
  end

  assign valid = (state == SLOT_FULL);

endmodule

// File: rtl/demux4_buf.sv
// 1-to-4 buffered demux: routes the input stream to one of four one-entry slots by in_sel.
module demux4_buf
  import demux4_buf_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_WIDTH
) (
  input  logic         clk,
  input  logic         reset,
  demux4_buf_if.slave  bus
);

  logic              accept;
  logic [NUM_CH-1:0] wr_en;
  logic [NUM_CH-1:0] slot_valid;
  logic [WIDTH-1:0]  slot_data [NUM_CH];
  logic [CNT_W-1:0]  count;

  assign bus.in_ready = ~slot_valid[bus.in_sel] | bus.out_ready[bus.in_sel];
  assign accept       = bus.in_valid & bus.in_ready;

  always_comb begin
    wr_en = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      wr_en[k] = accept && (bus.in_sel == SEL_W'(k));
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_slot
    demux_slot #(.WIDTH(WIDTH)) u_slot (
      .clk      (clk),
      .reset    (reset),
      .wr_en    (wr_en[g]),
      .wr_data  (bus.in_data),
      .rd_ready (bus.out_ready[g]),
      .valid    (slot_valid[g]),
      .data     (slot_data[g])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (accept) begin
      count <= count + 1'b1;
    end
  end

  assign bus.out_valid  = slot_valid;
  assign bus.out_data0  = slot_data[0];
  assign bus.out_data1  = slot_data[1];
  assign bus.out_data2  = slot_data[2];
  assign bus.out_data3  = slot_data[3];
  assign bus.xfer_count = count;

endmodule

// File: doc/demux4_buf.md
DEMUX4_BUF -- requirements
Module: demux4_buf

Interface
REQ-001 Parameter: WIDTH, 32, data width of every channel.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: in_valid  input  1  upstream word present.
REQ-005 Port: in_ready  output  1  block accepts word this cycle.
REQ-006 Port: in_data  input  WIDTH  upstream word.
REQ-007 Port: in_sel  input  2  destination channel index, 0..3.
REQ-008 Port: out_valid  output  4  bit k = channel k holds a word.
REQ-009 Port: out_ready  input  4  bit k = channel k consumer takes word.
REQ-010 Port: out_data0, out_data1, out_data2, out_data3  output  WIDTH each  channel word.
REQ-011 Port: xfer_count  output  8  number of accepted words, modulo 256.

Function
REQ-012 The block SHALL be the 1-to-4 counterpart of the datapath 4:1 mux: one input stream routed to one of four buffered output channels by in_sel.
REQ-013 Each channel SHALL hold a one-entry slot with two states: EMPTY (out_valid[k]=0) and FULL (out_valid[k]=1).
REQ-014 Accept condition: in_valid & in_ready; in_ready SHALL equal ~out_valid[in_sel] | out_ready[in_sel] (combinational, no dependence on in_valid).
REQ-015 Pop condition for channel k: out_valid[k] & out_ready[k].
REQ-016 EMPTY->FULL on accept to k; FULL->EMPTY on pop without accept to k; FULL stays FULL with new data on simultaneous pop and accept to k.
REQ-017 Latency SHALL be exactly one cycle: word accepted at edge N appears on out_dataK with out_valid[k]=1 after edge N.
REQ-018 out_dataK SHALL remain stable while out_valid[k]=1 and out_ready[k]=0.
REQ-019 out_dataK SHALL retain last value after pop (no clearing); only reset clears it.
REQ-020 Channels not addressed by in_sel SHALL be unaffected by the accept, and SHALL pop independently in the same cycle.
REQ-021 At most one word SHALL be accepted per cycle; no word SHALL be duplicated or dropped.
REQ-022 in_data and in_sel SHALL be ignored when in_valid=0; in_sel value is irrelevant when no accept occurs.
REQ-023 xfer_count SHALL increment by 1 per accept, wrapping 255->0 without flag.
REQ-024 out_ready asserted on an EMPTY channel SHALL have no effect.

Reset
REQ-025 While reset=1: out_valid=4'b0000, all out_dataK=0, xfer_count=0, regardless of clk.
REQ-026 Reset mid-operation SHALL discard all buffered words; in_ready reflects empty slots (=1) from reset release onward.
REQ-027 No accept SHALL be recorded on an edge where reset=1.

Structure
REQ-028 WIDTH default and channel-count constant (4) SHALL live in the shared datapath package/header used by the mux blocks.
REQ-029 One sub-module, demux_slot (one-entry valid/ready buffer, WIDTH-parameterised), SHALL be instantiated four times; top level holds select decode, in_ready mux and counter.

Verification
REQ-030 After reset, in_valid=1, in_sel=2, in_data=32'hDEADBEEF, out_ready=0 one cycle -> next cycle out_valid=4'b0100, out_data2=32'hDEADBEEF, xfer_count=1.
REQ-031 Channel 1 FULL with 32'h11, out_ready[1]=0, new word 32'h22 to sel 1 -> in_ready=0, out_data1 stays 32'h11 for 5 cycles, xfer_count unchanged.
REQ-032 Channel 3 FULL with 32'hA, out_ready[3]=1 and accept 32'hB to sel 3 same cycle -> out_valid[3] stays 1, out_data3=32'hB, one pop and one accept counted.
REQ-033 Back-to-back words 1,2,3,4 to sel 0,1,2,3 with out_ready=0 -> out_valid=4'b1111 after 4 cycles, each channel holds its word, xfer_count=4.
REQ-034 256 accepts to sel 0 with out_ready[0]=1 -> xfer_count wraps to 0, last out_data0 = word 256.
REQ-035 Assert reset asynchronously mid-stream with out_valid=4'b1011 -> out_valid=0, out_data all 0, xfer_count=0 immediately, in_ready=1 after release.
